// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants and types for the data-memory responder:
//                RISC-V load/store funct3 encodings and the FSM state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size / sign encodings used in funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational lane logic for the data-memory responder.
//                Builds byte enables and lane-replicated store data, extracts
//                and extends load data, and flags misaligned/illegal accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        err_o
);

  logic [1:0]  w_size;
  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_shift;

  // Decode size, detect errors, then build enables and load result.
  always_comb begin
    w_size   = funct3_i[1:0];
    be_o     = 4'b0000;
    wdata_o  = wdata_i;
    load_o   = 32'h0;
    // Stores only have unsigned-free B/H/W; loads reject 011, 110, 111.
    if (is_store_i) begin
      w_illegal = funct3_i[2] | (w_size == 2'b11);
    end else begin
      w_illegal = (w_size == 2'b11) | (funct3_i == 3'b110);
    end
    w_misalign = ((w_size == 2'b01) & addr_lo_i[0]) |
                 ((w_size == 2'b10) & (addr_lo_i != 2'b00));
    err_o   = w_illegal | w_misalign;
    // Bring the addressed byte/half down to bit 0.
    w_shift = rword_i >> {addr_lo_i, 3'b000};

    case (w_size)
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = funct3_i[2] ? {24'h0, w_shift[7:0]}
                              : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        load_o  = funct3_i[2] ? {16'h0, w_shift[15:0]}
                              : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      2'b10: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        load_o  = rword_i;
      end
      default: begin
        be_o    = 4'b0000;
        load_o  = 32'h0;
      end
    endcase

    // A faulting access never writes and never returns data.
    if (err_o) begin
      be_o   = 4'b0000;
      load_o = 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_resp
//  Description : Responder end of the core data-memory interface. Accepts a
//                load/store in IDLE, waits WAIT_CYCLES cycles, then commits the
//                store / captures the formatted load and pulses ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLOCK,
  input  logic        RST,
  input  logic        ena_rd,
  input  logic        ena_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_init =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              store_q, store_d;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              err_q;
  logic [31:0]       mem_q [0:(2**ADDR_W)-1];

  logic              w_commit;
  logic [ADDR_W+1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [2:0]        w_sel_funct3;
  logic              w_sel_store;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_load;
  logic              w_err;

  // Upper address bits are deliberately ignored so accesses wrap.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, addr[31:ADDR_W+2]};

  // Next-state, counter and request capture; flags the commit edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    w_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena_wr | ena_rd) begin
          addr_d   = addr[ADDR_W+1:0];
          wdata_d  = wdata;
          funct3_d = funct3;
          store_d  = ena_wr;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = c_cnt_init;
          end else begin
            state_d  = RESP;
            w_commit = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          w_commit = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so the
  // datapath must look at the live inputs while IDLE and the latched copy later.
  always_comb begin
    if (state_q == IDLE) begin
      w_sel_addr   = addr[ADDR_W+1:0];
      w_sel_wdata  = wdata;
      w_sel_funct3 = funct3;
      w_sel_store  = ena_wr;
    end else begin
      w_sel_addr   = addr_q;
      w_sel_wdata  = wdata_q;
      w_sel_funct3 = funct3_q;
      w_sel_store  = store_q;
    end
  end

  assign w_idx   = w_sel_addr[ADDR_W+1:2];
  assign w_rword = mem_q[w_idx];

  mem_lane_align u_align (
    .addr_lo_i  (w_sel_addr[1:0]),
    .funct3_i   (w_sel_funct3),
    .is_store_i (w_sel_store),
    .wdata_i    (w_sel_wdata),
    .rword_i    (w_rword),
    .be_o       (w_be),
    .wdata_o    (w_wdata_sh),
    .load_o     (w_load),
    .err_o      (w_err)
  );

  // FSM state, counter and latched request.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
    end
  end

  // Response registers: ready/err pulse for the RESP cycle, rdata held.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= w_commit;
      err_q   <= w_commit & w_err;
      if (w_commit) begin
        if (w_err) begin
          rdata_q <= 32'h0;
        end else if (!w_sel_store) begin
          rdata_q <= w_load;
        end
      end
    end
  end

  // RAM array: byte-lane writes on the commit edge, contents never reset.
  always_ff @(posedge CLOCK) begin
    if (!RST && w_commit && w_sel_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          mem_q[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_resp
//  Description : Directed self-checking bench for data_mem_resp. Three
//                instances cover WAIT_CYCLES = 1, 3 and 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        t_rd    [3];
  logic        t_wr    [3];
  logic [31:0] t_addr  [3];
  logic [31:0] t_wdata [3];
  logic [2:0]  t_f3    [3];
  logic [31:0] t_rdata [3];
  logic        t_ready [3];
  logic        t_err   [3];

  int total = 0;
  int bad   = 0;

  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .CLOCK(clk), .RST(rst), .ena_rd(t_rd[0]), .ena_wr(t_wr[0]),
    .addr(t_addr[0]), .wdata(t_wdata[0]), .funct3(t_f3[0]),
    .rdata(t_rdata[0]), .ready(t_ready[0]), .err(t_err[0]));

  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .CLOCK(clk), .RST(rst), .ena_rd(t_rd[1]), .ena_wr(t_wr[1]),
    .addr(t_addr[1]), .wdata(t_wdata[1]), .funct3(t_f3[1]),
    .rdata(t_rdata[1]), .ready(t_ready[1]), .err(t_err[1]));

  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .CLOCK(clk), .RST(rst), .ena_rd(t_rd[2]), .ena_wr(t_wr[2]),
    .addr(t_addr[2]), .wdata(t_wdata[2]), .funct3(t_f3[2]),
    .rdata(t_rdata[2]), .ready(t_ready[2]), .err(t_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request: present at a negedge, accepted at the next posedge, then the
  // bus is scrambled. lat = number of negedges until ready is seen high.
  task automatic do_req(input int k, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, output logic [31:0] rd,
                        output logic er, output int lat);
    @(negedge clk);
    t_wr[k] = w; t_rd[k] = r; t_addr[k] = a; t_wdata[k] = d; t_f3[k] = f;
    @(posedge clk);
    #1;
    t_wr[k] = 1'b0; t_rd[k] = 1'b0;
    t_addr[k] = 32'hFFFF_FFFC; t_wdata[k] = ~d; t_f3[k] = 3'b111;
    lat = 0; rd = 'x; er = 'x;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (t_ready[k]) begin
        lat = n; rd = t_rdata[k]; er = t_err[k];
      end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL timeout inst=%0d addr=%h: no ready within 20 cycles", k, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (t_ready[k] !== 1'b0) begin bad++; $display("FAIL reset_ready inst=%0d got=%b exp=0", k, t_ready[k]); end
      total++;
      if (t_err[k] !== 1'b0) begin bad++; $display("FAIL reset_err inst=%0d got=%b exp=0", k, t_err[k]); end
      total++;
      if (t_rdata[k] !== 32'h0) begin bad++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", k, t_rdata[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, F3_W, rd, er, lat);
    total++;
    if (lat != 2 || er !== 1'b0) begin bad++; $display("FAIL sw_lat lat=%0d err=%b exp lat=2 err=0", lat, er); end
    do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, F3_W, rd, er, lat);
    total++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_word lat=%0d err=%b got=%h exp lat=2 err=0 DEADBEEF", lat, er, rd);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1'b1, 1'b0, 32'h11, 32'h80, F3_B, rd, er, lat);
    do_req(0, 1'b0, 1'b1, 32'h11, 32'h0, F3_B, rd, er, lat);
    total++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin bad++; $display("FAIL lb got=%h err=%b exp FFFFFF80", rd, er); end
    do_req(0, 1'b0, 1'b1, 32'h11, 32'h0, F3_BU, rd, er, lat);
    total++;
    if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp 00000080", rd); end
    do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, F3_W, rd, er, lat);
    total++;
    if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL sb_merge got=%h exp DEAD80EF", rd); end
  endtask

  task automatic test_half_err();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1'b1, 1'b0, 32'h12, 32'h00008001, F3_H, rd, er, lat);
    do_req(0, 1'b0, 1'b1, 32'h12, 32'h0, F3_H, rd, er, lat);
    total++;
    if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh got=%h exp FFFF8001", rd); end
    do_req(0, 1'b0, 1'b1, 32'h12, 32'h0, F3_HU, rd, er, lat);
    total++;
    if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu got=%h exp 00008001", rd); end
    do_req(0, 1'b0, 1'b1, 32'h13, 32'h0, F3_W, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin bad++; $display("FAIL lw_misalign err=%b got=%h lat=%0d exp err=1 0 lat=2", er, rd, lat); end
    do_req(0, 1'b1, 1'b0, 32'h11, 32'hFFFFFFFF, F3_H, rd, er, lat);
    total++;
    if (er !== 1'b1) begin bad++; $display("FAIL sh_misalign err=%b exp 1", er); end
    do_req(0, 1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, F3_BU, rd, er, lat);
    total++;
    if (er !== 1'b1) begin bad++; $display("FAIL st_illegal err=%b exp 1", er); end
    do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b011, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL ld_illegal err=%b got=%h exp err=1 0", er, rd); end
    do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, F3_W, rd, er, lat);
    total++;
    if (rd !== 32'h800180EF || er !== 1'b0) begin bad++; $display("FAIL word_after_err got=%h err=%b exp 800180EF", rd, er); end
    @(negedge clk);
    total++;
    if (t_ready[0] !== 1'b0 || t_err[0] !== 1'b0) begin bad++; $display("FAIL pulse_width ready=%b err=%b exp 0 0", t_ready[0], t_err[0]); end
  endtask

  task automatic test_wrap_both();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1'b1, 1'b0, 32'h1000, 32'h12345678, F3_W, rd, er, lat);
    do_req(0, 1'b0, 1'b1, 32'h0, 32'h0, F3_W, rd, er, lat);
    total++;
    if (rd !== 32'h12345678) begin bad++; $display("FAIL wrap got=%h exp 12345678", rd); end
    do_req(0, 1'b1, 1'b0, 32'h4, 32'h0, F3_W, rd, er, lat);
    do_req(0, 1'b1, 1'b1, 32'h4, 32'h55AA55AA, F3_W, rd, er, lat);
    total++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin bad++; $display("FAIL both_no_load got=%h err=%b exp 12345678 0", rd, er); end
    do_req(0, 1'b0, 1'b1, 32'h4, 32'h0, F3_W, rd, er, lat);
    total++;
    if (rd !== 32'h55AA55AA) begin bad++; $display("FAIL both_store got=%h exp 55AA55AA", rd); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 1'b1, 1'b0, 32'h20, 32'h11111111, F3_W, rd, er, lat);
    total++;
    if (lat != 4) begin bad++; $display("FAIL w3_lat got=%0d exp 4", lat); end
    @(negedge clk);
    t_wr[1] = 1'b1; t_addr[1] = 32'h20; t_wdata[1] = 32'hAAAAAAAA; t_f3[1] = F3_W;
    @(posedge clk);
    #1;
    t_wr[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (t_ready[1] !== 1'b0 || t_rdata[1] !== 32'h0) begin bad++; $display("FAIL rst_wait ready=%b rdata=%h exp 0 0", t_ready[1], t_rdata[1]); end
    do_req(1, 1'b0, 1'b1, 32'h20, 32'h0, F3_W, rd, er, lat);
    total++;
    if (rd !== 32'h11111111 || lat != 4) begin bad++; $display("FAIL dropped_store got=%h lat=%0d exp 11111111 4", rd, lat); end
    do_req(2, 1'b1, 1'b0, 32'h8, 32'hCAFEF00D, F3_W, rd, er, lat);
    total++;
    if (lat != 1) begin bad++; $display("FAIL w0_store_lat got=%0d exp 1", lat); end
    do_req(2, 1'b0, 1'b1, 32'h8, 32'h0, F3_W, rd, er, lat);
    total++;
    if (lat != 1 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL w0_load lat=%0d got=%h exp 1 CAFEF00D", lat, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    int pulses, dbl, first, extra;
    logic prev;
    pulses = 0; dbl = 0; first = 0; extra = 0; prev = 1'b0;
    @(negedge clk);
    t_wr[0] = 1'b1; t_addr[0] = 32'h40; t_wdata[0] = 32'h0BADF00D; t_f3[0] = F3_W;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (t_ready[0]) begin
        pulses++;
        if (first == 0) first = n;
        if (prev) dbl++;
      end
      prev = t_ready[0];
    end
    t_wr[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (t_ready[0]) extra++;
    end
    total++;
    if (pulses != 4 || first != 2) begin bad++; $display("FAIL b2b_pulses got=%0d first=%0d exp 4 first=2", pulses, first); end
    total++;
    if (dbl != 0 || extra != 0) begin bad++; $display("FAIL b2b_width long=%0d extra=%0d exp 0 0", dbl, extra); end
    do_req(0, 1'b0, 1'b1, 32'h40, 32'h0, F3_W, rd, er, lat);
    total++;
    if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_data got=%h exp 0BADF00D", rd); end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t_rd[k] = 1'b0; t_wr[k] = 1'b0; t_addr[k] = '0; t_wdata[k] = '0; t_f3[k] = '0;
    end
    test_reset();
    test_word();
    test_byte();
    test_half_err();
    test_wrap_both();
    test_reset_in_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
